// File: rtl/nios_system_pattern_match_timer.sv
// Avalon-MM pattern-match reaction timer: latches the LED pattern on START and counts cycles until the switches hold it.
// Optional interrupt output enabled by defining PATTERN_MATCH_IRQ_EN.
module nios_system_pattern_match_timer #(
  parameter int WIDTH         = 18,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] switches,
  output logic             irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TOUT = 2'd3;

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       limit_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic [WIDTH-1:0]  sw_meta_q, sw_sync_q;
  logic              irq_en_rd;

  logic wr, wr_ctrl, wr_limit, wr_irqctl;
  logic start, abort, ack;
  logic match, qualified, timed_out;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign wr_limit  = wr & (address == 2'd2);
  assign wr_irqctl = wr & (address == 2'd3);
  assign start     = wr_ctrl & writedata[0];
  assign abort     = wr_ctrl & writedata[1];
  assign ack       = wr_irqctl & writedata[1];

  assign match     = (sw_sync_q == pat_q);
  assign qualified = match && (stab_q == STAB_LAST);
  assign timed_out = (limit_q != 32'd0) && (count_q == limit_q);

  // Synchronizer stage for the asynchronous slide switches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ABORT beats START; a qualified match beats the timeout on the same cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stab_d  = stab_q;
    pat_d   = pat_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
      pat_d   = pattern;
      count_d = 32'd0;
      stab_d  = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          stab_d = match ? stab_q + STAB_W'(1) : '0;
          if (qualified) begin
            state_d = S_DONE;
            count_d = sat_inc(count_q);
          end else if (timed_out) begin
            state_d = S_TOUT;
          end else begin
            count_d = sat_inc(count_q);
          end
        end
        S_DONE, S_TOUT: if (ack) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  // Control and measurement registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= 32'd0;
      stab_q  <= '0;
      pat_q   <= '0;
      limit_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stab_q  <= stab_d;
      pat_q   <= pat_d;
      if (wr_limit) limit_q <= writedata;
    end
  end

`ifdef PATTERN_MATCH_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       irq_en_q <= 1'b0;
    else if (wr_irqctl) irq_en_q <= writedata[0];
  end
  assign irq_en_rd = irq_en_q;
  assign irq       = irq_en_q & ((state_q == S_DONE) | (state_q == S_TOUT));
`else
  assign irq_en_rd = 1'b0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {29'd0, state_q == S_TOUT, state_q == S_DONE, state_q == S_RUN};
      2'd1: readdata = count_q;
      2'd2: readdata = limit_q;
      2'd3: readdata = {31'd0, irq_en_rd};
      default: readdata = 32'd0;
    endcase
  end

endmodule
